// File: rtl/hcms_pkg.sv
// hcms_pkg
// Shared definitions for the HCMS-29xx display-link receiver:
//   - receiver state encoding
//   - register-select encodings and the control-word select bit
//   - control-word field positions (for consumers of o_ctrl0 / o_ctrl1)
//   - pin ordering used by the per-pin synchronizer array
//   - column-buffer depth derivation
package hcms_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // chip enable high, waiting for a window
        ST_SHIFT = 2'd1,   // chip enable low, assembling bytes
        ST_HOLD  = 2'd2    // display held in reset
    } rx_state_e;

    // Register select pin encodings
    localparam logic REGSEL_DATA = 1'b0;
    localparam logic REGSEL_CMD  = 1'b1;

    // Bit 7 of a control byte selects control word 0 or 1
    localparam int CTRL_SEL_BIT = 7;

    // Control word 0 fields
    localparam int CTRL0_BRIGHT_LSB = 0;
    localparam int CTRL0_BRIGHT_MSB = 3;
    localparam int CTRL0_PEAK_LSB   = 4;
    localparam int CTRL0_PEAK_MSB   = 5;
    localparam int CTRL0_SLEEP_BIT  = 6;
    // Control word 1 fields
    localparam int CTRL1_MODE_BIT   = 0;   // serial / simultaneous data-out mode

    // Index of each display pin inside the synchronizer array
    localparam int PIN_DATA   = 0;
    localparam int PIN_SCLK   = 1;
    localparam int PIN_REGSEL = 2;
    localparam int PIN_NCS    = 3;
    localparam int PIN_NRESET = 4;
    localparam int NUM_PINS   = 5;

    // Depth of the column (dot) buffer
    function automatic int num_cols(input int n_chars, input int n_cols_per_char);
        return n_chars * n_cols_per_char;
    endfunction

endpackage

// File: rtl/hcms_pin_sync.sv
// hcms_pin_sync
// Brings one asynchronous display pin into the i_CLK domain and produces a
// registered rising-edge strobe.
//   i_CLK    system clock
//   i_reset  synchronous active-high reset (chain loads RESET_VAL)
//   i_pin    raw asynchronous pin
//   o_level  synchronized pin level, delayed to line up with o_rise
//   o_rise   one-cycle strobe: synchronized pin went 0 -> 1
// Every pin goes through the same pipeline, so o_level of a data pin is
// cycle-aligned with o_rise of the clock pin.
module hcms_pin_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic i_CLK,
    input  logic i_reset,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;
    logic                   rise_reg;

    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            sync_reg <= {SYNC_STAGES{RESET_VAL}};
            prev_reg <= RESET_VAL;
            rise_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], i_pin};
            prev_reg <= sync_reg[SYNC_STAGES-1];
            rise_reg <= sync_reg[SYNC_STAGES-1] & ~prev_reg;
        end
    end

    assign o_level = prev_reg;
    assign o_rise  = rise_reg;

endmodule

// File: rtl/hcms_rx.sv
// hcms_rx
// Receive side of the HCMS-29xx serial display link. Samples the display pins,
// rebuilds bytes MSB-first and routes them to the column buffer (regsel = 0)
// or to the two control words (regsel = 1).
//   i_CLK, i_reset             system clock, synchronous active-high reset
//   i_hcms_*                   raw display pins (async to i_CLK)
//   o_col_valid/idx/data       pulse + column index + byte for each data write
//   o_frame_done               pulse with the write to the last column
//   o_ctrl0/o_ctrl1            latest control words, o_ctrl_valid pulses on update
//   o_err_partial              pulse when chip enable rose mid-byte
//   i_rd_idx/o_rd_data         buffer read port, one cycle latency
module hcms_rx
    import hcms_pkg::*;
#(
    parameter int N_CHARS         = 4,
    parameter int N_COLS_PER_CHAR = 5,
    parameter int SYNC_STAGES     = 2,
    localparam int NUM_COLS       = num_cols(N_CHARS, N_COLS_PER_CHAR),
    localparam int IDX_W          = $clog2(NUM_COLS)
) (
    input  logic             i_CLK,
    input  logic             i_reset,
    input  logic             i_hcms_data,
    input  logic             i_hcms_clock,
    input  logic             i_hcms_regsel,
    input  logic             i_hcms_ncs,
    input  logic             i_hcms_nreset,
    output logic             o_col_valid,
    output logic [IDX_W-1:0] o_col_idx,
    output logic [7:0]       o_col_data,
    output logic             o_frame_done,
    output logic [7:0]       o_ctrl0,
    output logic [7:0]       o_ctrl1,
    output logic             o_ctrl_valid,
    output logic             o_err_partial,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [7:0]       o_rd_data
);

    localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(NUM_COLS - 1);
    // Chip enable and display reset idle high so that leaving i_reset does
    // not look like a window opening or a display reset.
    localparam logic [NUM_PINS-1:0] PIN_RST_VAL = 5'b11000;

    // ------------------------------------------------------------------
    // Pin synchronizers
    // ------------------------------------------------------------------
    logic [NUM_PINS-1:0] pin_vec;
    logic [NUM_PINS-1:0] level_vec;
    logic [NUM_PINS-1:0] rise_vec;

    assign pin_vec = {i_hcms_nreset, i_hcms_ncs, i_hcms_regsel, i_hcms_clock, i_hcms_data};

    for (genvar gi = 0; gi < NUM_PINS; gi++) begin : g_sync
        hcms_pin_sync #(
            .SYNC_STAGES (SYNC_STAGES),
            .RESET_VAL   (PIN_RST_VAL[gi])
        ) u_sync (
            .i_CLK   (i_CLK),
            .i_reset (i_reset),
            .i_pin   (pin_vec[gi]),
            .o_level (level_vec[gi]),
            .o_rise  (rise_vec[gi])
        );
    end

    logic data_s, regsel_s, ncs_s, nreset_s, sclk_rise;
    assign data_s    = level_vec[PIN_DATA];
    assign regsel_s  = level_vec[PIN_REGSEL];
    assign ncs_s     = level_vec[PIN_NCS];
    assign nreset_s  = level_vec[PIN_NRESET];
    assign sclk_rise = rise_vec[PIN_SCLK];

    // Only the serial clock needs an edge strobe; state changes on the other
    // pins are level-driven.
    logic unused_rise;
    assign unused_rise = ^{rise_vec[PIN_NRESET], rise_vec[PIN_NCS],
                           rise_vec[PIN_REGSEL], rise_vec[PIN_DATA]};

    // ------------------------------------------------------------------
    // Byte assembly / routing FSM
    // ------------------------------------------------------------------
    rx_state_e        state_reg;
    logic [2:0]       bit_cnt_reg;
    logic [7:0]       shift_reg;
    logic [IDX_W-1:0] col_ptr_reg;
    logic             col_valid_reg, frame_done_reg, ctrl_valid_reg, err_partial_reg;
    logic [IDX_W-1:0] col_idx_reg;
    logic [7:0]       col_data_reg, ctrl0_reg, ctrl1_reg;

    logic [7:0] byte_next;
    logic       byte_done;
    logic       buf_wr_en;

    assign byte_next = {shift_reg[6:0], data_s};
    // Eighth bit edge inside an open window; a display reset in the same
    // cycle wins and the byte is dropped.
    assign byte_done = (state_reg == ST_SHIFT) && nreset_s && sclk_rise && (bit_cnt_reg == 3'd7);
    assign buf_wr_en = !i_reset && byte_done && (regsel_s == REGSEL_DATA);

    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            state_reg       <= ST_IDLE;
            bit_cnt_reg     <= 3'd0;
            shift_reg       <= 8'd0;
            col_ptr_reg     <= '0;
            col_valid_reg   <= 1'b0;
            col_idx_reg     <= '0;
            col_data_reg    <= 8'd0;
            frame_done_reg  <= 1'b0;
            ctrl0_reg       <= 8'd0;
            ctrl1_reg       <= 8'd0;
            ctrl_valid_reg  <= 1'b0;
            err_partial_reg <= 1'b0;
        end else begin
            col_valid_reg   <= 1'b0;
            frame_done_reg  <= 1'b0;
            ctrl_valid_reg  <= 1'b0;
            err_partial_reg <= 1'b0;

            if (!nreset_s) begin
                state_reg   <= ST_HOLD;
                bit_cnt_reg <= 3'd0;
                shift_reg   <= 8'd0;
                col_ptr_reg <= '0;
                ctrl0_reg   <= 8'd0;
                ctrl1_reg   <= 8'd0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (!ncs_s) begin
                            state_reg   <= ST_SHIFT;
                            bit_cnt_reg <= 3'd0;
                        end
                    end

                    ST_SHIFT: begin
                        if (sclk_rise) begin
                            shift_reg   <= byte_next;
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;  // 7 -> 0 closes the byte
                        end
                        if (byte_done) begin
                            if (regsel_s == REGSEL_DATA) begin
                                col_valid_reg <= 1'b1;
                                col_idx_reg   <= col_ptr_reg;
                                col_data_reg  <= byte_next;
                                if (col_ptr_reg == LAST_COL) begin
                                    col_ptr_reg    <= '0;
                                    frame_done_reg <= 1'b1;
                                end else begin
                                    col_ptr_reg <= col_ptr_reg + IDX_W'(1);
                                end
                            end else begin
                                ctrl_valid_reg <= 1'b1;
                                if (byte_next[CTRL_SEL_BIT]) begin
                                    ctrl1_reg <= byte_next;
                                end else begin
                                    ctrl0_reg <= byte_next;
                                end
                            end
                        end
                        // Window closed: a byte finishing on this very edge
                        // still counts; anything else partial is dropped.
                        if (ncs_s) begin
                            state_reg   <= ST_IDLE;
                            bit_cnt_reg <= 3'd0;
                            shift_reg   <= 8'd0;
                            if ((bit_cnt_reg != 3'd0) && !byte_done) begin
                                err_partial_reg <= 1'b1;
                            end
                        end
                    end

                    ST_HOLD: begin
                        state_reg   <= ncs_s ? ST_IDLE : ST_SHIFT;
                        bit_cnt_reg <= 3'd0;
                    end

                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Column buffer: not cleared by either reset
    // ------------------------------------------------------------------
    logic [7:0] buf_mem [NUM_COLS];
    logic [7:0] rd_data_reg;

    always_ff @(posedge i_CLK) begin
        if (buf_wr_en) begin
            buf_mem[col_ptr_reg] <= byte_next;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            rd_data_reg <= 8'd0;
        end else if (i_rd_idx <= LAST_COL) begin
            rd_data_reg <= buf_mem[i_rd_idx];
        end else begin
            rd_data_reg <= 8'd0;
        end
    end

    assign o_col_valid   = col_valid_reg;
    assign o_col_idx     = col_idx_reg;
    assign o_col_data    = col_data_reg;
    assign o_frame_done  = frame_done_reg;
    assign o_ctrl0       = ctrl0_reg;
    assign o_ctrl1       = ctrl1_reg;
    assign o_ctrl_valid  = ctrl_valid_reg;
    assign o_err_partial = err_partial_reg;
    assign o_rd_data     = rd_data_reg;

endmodule
